// File: rtl/bram_capture_if.sv
// BRAM port bundle between the capture engine (master) and a single-port BRAM (slave).
// Latency: none of its own; the BRAM returns dout one cycle after an enabled read.
// Backpressure: none; the BRAM accepts one access per cycle unconditionally.
interface bram_capture_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  logic              enable;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;

  modport master (output enable, output we, output addr, output din, input dout);
  modport slave  (input enable, input we, input addr, input din, output dout);
endinterface

// File: rtl/bram_capture.sv
// Captures multi-channel samples into a BRAM frame; word 0 is the host control/status word.
// Latency: first channel written the cycle after valid; NUM_CH+2 cycles per sample (NUM_CH+1 for the last).
// Backpressure: none; a valid strobe outside ARMED is dropped and flagged on sticky overflow.
module bram_capture #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid,
  input  logic [NUM_CH*DATA_W-1:0] datos,
  bram_capture_if.master           bram,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     overflow
);

  localparam int MAX_SAMP = (DEPTH - 1) / NUM_CH;
  localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W    = $clog2(MAX_SAMP + 1);
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] BYTES = ADDR_W'(DATA_W / 8);

  typedef enum logic [2:0] {
    POLL_RD, POLL_CHK, ARMED, WRITE, CHK_RD, CHK_EVAL, CLOSE
  } state_t;

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic                     ovf_q, ovf_d;
  logic [NUM_CH*DATA_W-1:0] samp_q, samp_d;

  logic [DATA_W-1:0]        status_word;

  // Host writes the arm bit; the closing write reports sample count with bit 0 cleared to disarm.
  assign status_word = DATA_W'({cnt_q, 1'b0});
  assign overflow    = ovf_q;

  // Next-state and datapath update for the capture sequencer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    ovf_d   = ovf_q;
    samp_d  = samp_q;

    // A strobe is only acceptable in ARMED; while polling the host has not armed us, so no flag.
    if (valid && !(state_q inside {POLL_RD, POLL_CHK, ARMED})) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      POLL_RD: state_d = POLL_CHK;
      POLL_CHK: begin
        if (bram.dout[0]) begin
          ptr_d   = PTR_W'(1);
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ARMED;
        end else begin
          state_d = POLL_RD;
        end
      end
      ARMED: begin
        if (valid) begin
          samp_d  = datos;
          ch_d    = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (ch_q == CH_W'(NUM_CH - 1)) begin
          ch_d  = '0;
          cnt_d = cnt_q + CNT_W'(1);
          // Next sample would spill past the last word: close the frame and leave ptr in range.
          if (int'(ptr_q) + NUM_CH > DEPTH - 1) begin
            state_d = CLOSE;
          end else begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = CHK_RD;
          end
        end else begin
          ch_d  = ch_q + CH_W'(1);
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      CHK_RD: state_d = CHK_EVAL;
      CHK_EVAL: begin
        if (bram.dout[0]) begin
          state_d = ARMED;
        end else begin
          // Host dropped the arm bit mid-frame: discard the frame and restart polling.
          ptr_d   = PTR_W'(1);
          cnt_d   = '0;
          state_d = POLL_RD;
        end
      end
      CLOSE: state_d = POLL_RD;
      default: state_d = POLL_RD;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= POLL_RD;
      ptr_q   <= PTR_W'(1);
      cnt_q   <= '0;
      ch_q    <= '0;
      ovf_q   <= 1'b0;
      samp_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      ovf_q   <= ovf_d;
      samp_q  <= samp_d;
    end
  end

  // BRAM strobes decoded from state; forced idle while rst is high so a reset mid-write stops at once.
  always_comb begin
    bram.enable = 1'b0;
    bram.we     = 1'b0;
    bram.addr   = '0;
    bram.din    = '0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    if (!rst) begin
      case (state_q)
        POLL_RD: bram.enable = 1'b1;
        WRITE: begin
          bram.enable = 1'b1;
          bram.we     = 1'b1;
          bram.addr   = ADDR_W'(ptr_q) * BYTES;
          bram.din    = samp_q[int'(ch_q)*DATA_W +: DATA_W];
          busy        = 1'b1;
        end
        CHK_RD: begin
          bram.enable = 1'b1;
          busy        = 1'b1;
        end
        CHK_EVAL: busy = 1'b1;
        CLOSE: begin
          bram.enable = 1'b1;
          bram.we     = 1'b1;
          bram.din    = status_word;
          busy        = 1'b1;
          frame_done  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_capture.sv
// Directed bench for bram_capture with a behavioural single-port BRAM (NUM_CH=2, DEPTH=9).
// Latency: outputs sampled on the falling edge, inputs driven there too.
// Backpressure: none; the host side is modelled by writes into word 0.
module tb_bram_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [63:0] datos;
  logic        busy, frame_done, overflow;

  logic [31:0] mem [0:8];
  logic        host_set;
  int          host_idx;
  logic [31:0] host_word;
  int          wr_cnt = 0;
  int          fd_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  bram_capture_if #(.DATA_W(32), .ADDR_W(32)) bus ();

  bram_capture #(.DATA_W(32), .ADDR_W(32), .NUM_CH(2), .DEPTH(9)) dut (
    .clk(clk), .rst(rst), .valid(valid), .datos(datos), .bram(bus),
    .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Read-first single-port BRAM with one-cycle read latency, plus a host write port.
  always @(posedge clk) begin
    int ai;
    ai = int'(bus.addr >> 2);
    if (bus.enable && ai <= 8) begin
      bus.dout <= mem[ai];
      if (bus.we) begin
        mem[ai] <= bus.din;
        wr_cnt  <= wr_cnt + 1;
      end
    end
    if (host_set) mem[host_idx] <= host_word;
  end

  // Count frame_done pulses.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic host(input int idx, input logic [31:0] w);
    host_idx  = idx;
    host_word = w;
    host_set  = 1'b1;
    tick();
    host_set  = 1'b0;
  endtask

  task automatic send(input logic [63:0] d);
    valid = 1'b1;
    datos = d;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; datos = '0;
    host_set = 1'b0; host_idx = 0; host_word = '0;
    for (int i = 0; i < 9; i++) mem[i] = 32'h0;

    // Reset state
    repeat (2) tick();
    chk("rst_enable", bus.enable, 0);
    chk("rst_we", bus.we, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_din", bus.din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overflow", overflow, 0);

    // Arm from reset
    host(0, 32'h1);
    rst = 1'b0;
    #1 chk("poll_rd_enable", bus.enable, 1);
    repeat (3) tick();
    chk("armed_enable", bus.enable, 0);
    chk("armed_busy", busy, 0);
    chk("armed_no_writes", wr_cnt, 0);
    tick();
    chk("armed_stays_idle", bus.enable, 0);

    // First sample: channel A to word 1, channel B to word 2, then status read
    send({32'hB, 32'hA});
    chk("s1_w0_we", bus.we, 1);
    chk("s1_w0_addr", bus.addr, 4);
    chk("s1_w0_din", bus.din, 32'hA);
    chk("s1_busy", busy, 1);
    tick();
    chk("s1_w1_addr", bus.addr, 8);
    chk("s1_w1_din", bus.din, 32'hB);
    tick();
    chk("s1_chk_rd_en", bus.enable, 1);
    chk("s1_chk_rd_we", bus.we, 0);
    chk("s1_chk_rd_addr", bus.addr, 0);
    chk("s1_chk_rd_din", bus.din, 0);
    repeat (3) tick();

    // Remaining three samples fill the frame, then CLOSE writes count 4 << 1
    send({32'hD, 32'hC});  repeat (6) tick();
    send({32'hF, 32'hE});  repeat (6) tick();
    send({32'h11, 32'h10}); repeat (6) tick();
    chk("frame_w1", mem[1], 32'hA);
    chk("frame_w4", mem[4], 32'hD);
    chk("frame_w5", mem[5], 32'hE);
    chk("frame_w8", mem[8], 32'h11);
    chk("close_status", mem[0], 32'h8);
    chk("frame_done_once", fd_cnt, 1);
    chk("frame_write_count", wr_cnt, 9);

    // Not armed: valid is ignored without overflow
    send({32'h99, 32'h98}); tick();
    chk("poll_valid_no_ovf", overflow, 0);
    chk("poll_valid_no_write", wr_cnt, 9);

    // Abort after sample 2: host clears arm bit before CHK_EVAL
    host(0, 32'h1); repeat (3) tick();
    send({32'h21, 32'h20}); repeat (6) tick();
    send({32'h23, 32'h22});
    host(0, 32'h0);
    repeat (6) tick();
    chk("abort_no_frame_done", fd_cnt, 1);
    chk("abort_no_close", mem[0], 32'h0);
    chk("abort_w3", mem[3], 32'h22);
    host(0, 32'h1); repeat (3) tick();
    send({32'h25, 32'h24});
    chk("rearm_addr", bus.addr, 4);
    chk("rearm_din", bus.din, 32'h24);
    repeat (4) tick();

    // Overflow: valid held one extra cycle lands in WRITE and is dropped
    valid = 1'b1; datos = {32'h27, 32'h26};
    tick();
    datos = {32'h29, 32'h28};
    tick();
    valid = 1'b0;
    chk("ovf_set", overflow, 1);
    repeat (6) tick();
    chk("ovf_sticky", overflow, 1);
    chk("ovf_w3", mem[3], 32'h26);
    chk("ovf_w4", mem[4], 32'h27);
    chk("ovf_dropped_not_written", mem[5], 32'hE);
    send({32'h2B, 32'h2A});
    host(0, 32'h0);
    repeat (6) tick();
    chk("ovf_kept_over_abort", overflow, 1);
    host(0, 32'h1); repeat (3) tick();
    chk("ovf_cleared_on_arm", overflow, 0);

    // Reset in the second WRITE cycle
    host(2, 32'hDEAD);
    valid = 1'b1; datos = {32'h31, 32'h30};
    tick();
    datos = {32'h33, 32'h32};
    tick();
    valid = 1'b0;
    chk("pre_rst_we", bus.we, 1);
    chk("pre_rst_addr", bus.addr, 8);
    chk("pre_rst_ovf", overflow, 1);
    rst = 1'b1;
    tick();
    chk("wrst_enable", bus.enable, 0);
    chk("wrst_we", bus.we, 0);
    chk("wrst_busy", busy, 0);
    chk("wrst_ovf", overflow, 0);
    chk("wrst_w1_kept", mem[1], 32'h30);
    chk("wrst_w2_untouched", mem[2], 32'hDEAD);
    rst = 1'b0;
    #1;
    chk("wrst_poll_rd_en", bus.enable, 1);
    chk("wrst_poll_rd_addr", bus.addr, 0);
    tick();
    chk("wrst_poll_chk_en", bus.enable, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_capture.md
BRAM_CAPTURE -- requirements
Module: bram_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning BRAM word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_W, default 32, meaning BRAM byte-address width.
REQ-003 SHALL have parameter NUM_CH, default 2, meaning channels per sample (1..8).
REQ-004 SHALL have parameter DEPTH, default 1024, meaning BRAM depth in words, word 0 included (>= NUM_CH+1).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port valid  input  1  one-cycle strobe: datos holds a sample.
REQ-008 SHALL have port datos  input  NUM_CH*DATA_W  sample; channel k at bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port dout  input  DATA_W  BRAM read data, 1-cycle read latency.
REQ-010 SHALL have port enable  output  1  BRAM port enable.
REQ-011 SHALL have port we  output  1  BRAM write enable (whole word).
REQ-012 SHALL have port addr  output  ADDR_W  BRAM byte address.
REQ-013 SHALL have port din  output  DATA_W  BRAM write data.
REQ-014 SHALL have port busy  output  1  high in every state except POLL and ARMED.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse when a full frame is closed.
REQ-016 SHALL have port overflow  output  1  sticky: a valid strobe was dropped.

Function
REQ-017 SHALL treat word 0 (addr 0) as the control/status word; dout[0]=1 means armed by host. Sample data occupies words 1..DEPTH-1.
REQ-018 SHALL step addr by DATA_W/8 per word; word index w maps to addr = w*(DATA_W/8).
REQ-019 SHALL implement states POLL_RD, POLL_CHK, ARMED, WRITE, CHK_RD, CHK_EVAL, CLOSE.
REQ-020 POLL_RD: enable=1, we=0, addr=0; next state POLL_CHK.
REQ-021 POLL_CHK: samples dout. If dout[0]=1: ptr=1, sample_cnt=0, overflow cleared, go to ARMED. Else go to POLL_RD.
REQ-022 ARMED: enable=0. On valid, latch all of datos, ch=0, and go to WRITE.
REQ-023 WRITE: enable=1, we=1, addr=ptr word, din=latched channel ch; ptr+1 and ch+1 each cycle. Exactly NUM_CH consecutive cycles; then sample_cnt+1.
REQ-024 After the last channel write: if ptr+NUM_CH > DEPTH-1 (next sample would not fit), go to CLOSE; else go to CHK_RD.
REQ-025 CHK_RD: enable=1, we=0, addr=0; next state CHK_EVAL.
REQ-026 CHK_EVAL: if dout[0]=1, go to ARMED. If dout[0]=0 (host abort/restart), ptr=1 and sample_cnt=0, go to POLL_RD, and no frame_done.
REQ-027 CLOSE: one cycle with enable=1, we=1, addr=0, din={sample_cnt, 1'b0} truncated to DATA_W; frame_done=1; next state POLL_RD.
REQ-028 A sample costs NUM_CH+2 cycles (NUM_CH+1 for the last sample of a frame). Valid asserted in any state other than ARMED SHALL drop that sample and set overflow.
REQ-029 Valid in POLL_RD/POLL_CHK (not armed) SHALL be ignored without setting overflow.
REQ-030 enable/we SHALL be 0 in every cycle not listed above; din SHALL be 0 whenever we=0.
REQ-031 ptr, sample_cnt and ch SHALL be sized by $clog2 of their ranges; ptr SHALL never address beyond word DEPTH-1.

Reset
REQ-032 With rst=1 at a clock edge, the block SHALL enter POLL_RD and clear ptr=1, ch=0, sample_cnt=0, overflow=0 and the latched sample.
REQ-033 During reset: enable=0, we=0, addr=0, din=0, busy=0, frame_done=0.
REQ-034 Reset during WRITE SHALL abort immediately with no further write; the partial sample remains in BRAM.

Verification (NUM_CH=2, DATA_W=32, DEPTH=9 -> 4 samples/frame)
REQ-035 Arm: dout=1 after reset -> POLL_CHK to ARMED within 2 cycles; busy=0, no writes.
REQ-036 Sample datos={32'hB,32'hA} with valid -> next two cycles write addr 4 din A, then addr 8 din B, we=1; then read addr 0.
REQ-037 Four spaced samples with dout=1 -> words 1..8 written; CLOSE writes addr 0 din 32'h8; frame_done pulses once.
REQ-038 dout=0 in CHK_EVAL after sample 2 -> POLL_RD; next arm writes the first sample at addr 4 again.
REQ-039 Valid re-asserted one cycle after the accepted valid -> sample dropped, overflow=1, stays 1 until re-arm or rst.
REQ-040 rst asserted in the 2nd WRITE cycle -> next cycle enable=0, we=0, state POLL_RD, overflow=0.
